// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_ctrl
//  Brief    : Fetch stage behind the PC register. Issues one imem request per
//             PC (req/ack), returns the word to decode (valid/ready) and
//             drives pc_hold_o so the PC only advances on delivery or flush.
//  Options  : FETCH_TIMEOUT_EN - bounded WAIT with sticky fetch_err_o
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter int          N_BIT       = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BIT-1:0] pc_i,
  output logic             pc_hold_o,
  input  logic             flush_i,
  output logic             imem_req_o,
  output logic [N_BIT-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      imem_rdata_i,
  output logic [31:0]      instr_o,
  output logic [N_BIT-1:0] instr_pc_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             fetch_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t             state_q;
  logic               req_q;
  logic [N_BIT-1:0]   addr_q;
  logic [31:0]        instr_q;
  logic [N_BIT-1:0]   instr_pc_q;
  logic               valid_q;
  logic               drop_q;     // outstanding request belongs to a flushed path
  logic               timeout_d;  // WAIT budget exhausted this cycle

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q;
  logic       err_q;

  // The TIMEOUT_CYC-th WAIT cycle without ack ends the request
  assign timeout_d = (state_q == S_WAIT) && !imem_ack_i && (cnt_q == TO_LAST);

  // WAIT cycle counter (restarted every ISSUE) and sticky error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        cnt_q <= 8'd0;
      end else if ((state_q == S_WAIT) && !imem_ack_i) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (timeout_d) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fetch_err_o = err_q;
`else
  logic unused_timeout_cfg;

  // No WAIT limit in this build: the counter and error flag do not exist
  assign timeout_d          = 1'b0;
  assign fetch_err_o        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC[7:0];
`endif

  // Fetch sequencer with all handshake outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      instr_q    <= NOP_WORD;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          // A flush here means pc_i is about to change: sample next cycle
          if (!flush_i) begin
            addr_q  <= pc_i;
            req_q   <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack_i) begin
            req_q  <= 1'b0;
            drop_q <= 1'b0;
            if (drop_q || flush_i) begin
              state_q <= S_ISSUE;
            end else begin
              instr_q    <= imem_rdata_i;
              instr_pc_q <= addr_q;
              valid_q    <= 1'b1;
              state_q    <= S_OUT;
            end
          end else if (timeout_d) begin
            req_q  <= 1'b0;
            drop_q <= 1'b0;
            // A NOP for a flushed address would let the PC step past the
            // redirect target, so a dropped request just refetches.
            if (drop_q || flush_i) begin
              state_q <= S_ISSUE;
            end else begin
              instr_q    <= NOP_WORD;
              instr_pc_q <= addr_q;
              valid_q    <= 1'b1;
              state_q    <= S_OUT;
            end
          end else if (flush_i) begin
            // The memory request cannot be aborted; discard its data later
            drop_q <= 1'b1;
          end
        end
        S_OUT: begin
          // Flush discards the word; otherwise ready delivers it
          if (flush_i || instr_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_ISSUE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The PC may move only on a flush or at the edge that ends a delivery
  assign pc_hold_o = ~(flush_i | ((state_q == S_OUT) & instr_ready_i));

  assign imem_req_o    = req_q;
  assign imem_addr_o   = addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_ctrl
//  Brief    : Directed, table-driven bench for instr_fetch_ctrl
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc_i;
  logic        pc_hold_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        fetch_err_o;

  int n_pass;
  int n_total;

  instr_fetch_ctrl #(
    .N_BIT       (32),
    .NOP_WORD    (NOP),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pc_i          (pc_i),
    .pc_hold_o     (pc_hold_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .fetch_err_o   (fetch_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_hold;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] pc, logic fl, logic ak, logic [31:0] rd,
                              logic rdy, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep, logic eh);
    vec_t v;
    v.pc = pc; v.flush = fl; v.ack = ak; v.rdata = rd; v.ready = rdy;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_ipc = ep;
    v.e_hold = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset_n       = 1'b0;
    pc_i          = 32'h0040_0000;
    flush_i       = 1'b0;
    imem_ack_i    = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;

    // pc, flush, ack, rdata, ready | req, addr, valid, instr, instr_pc, hold
    vecs.push_back(mk(32'h0040_0000,0,0,32'h0,0,         0,32'h0,        0,NOP,         32'h0,        1)); // IDLE
    vecs.push_back(mk(32'h0040_0000,0,0,32'h0,0,         0,32'h0,        0,NOP,         32'h0,        1)); // ISSUE
    vecs.push_back(mk(32'h0040_0000,0,1,32'h2008_0005,0, 1,32'h0040_0000,0,NOP,         32'h0,        1)); // WAIT ack
    vecs.push_back(mk(32'h0040_0000,0,0,32'h0,1,         0,32'h0040_0000,1,32'h2008_0005,32'h0040_0000,0)); // OUT ready
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,0,         0,32'h0040_0000,0,32'h2008_0005,32'h0040_0000,1)); // ISSUE
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,0,         1,32'h0040_0004,0,32'h2008_0005,32'h0040_0000,1)); // WAIT
    vecs.push_back(mk(32'h0040_0004,0,1,32'h8C09_0010,0, 1,32'h0040_0004,0,32'h2008_0005,32'h0040_0000,1)); // WAIT ack
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,0,         0,32'h0040_0004,1,32'h8C09_0010,32'h0040_0004,1)); // OUT stall
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,0,         0,32'h0040_0004,1,32'h8C09_0010,32'h0040_0004,1)); // OUT stall
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,0,         0,32'h0040_0004,1,32'h8C09_0010,32'h0040_0004,1)); // OUT stall
    vecs.push_back(mk(32'h0040_0004,0,0,32'h0,1,         0,32'h0040_0004,1,32'h8C09_0010,32'h0040_0004,0)); // OUT ready
    vecs.push_back(mk(32'h0040_0008,0,0,32'h0,0,         0,32'h0040_0004,0,32'h8C09_0010,32'h0040_0004,1)); // ISSUE
    vecs.push_back(mk(32'h0040_0008,1,0,32'h0,0,         1,32'h0040_0008,0,32'h8C09_0010,32'h0040_0004,0)); // WAIT flush
    vecs.push_back(mk(32'h0040_0100,0,0,32'h0,0,         1,32'h0040_0008,0,32'h8C09_0010,32'h0040_0004,1)); // WAIT
    vecs.push_back(mk(32'h0040_0100,0,0,32'h0,0,         1,32'h0040_0008,0,32'h8C09_0010,32'h0040_0004,1)); // WAIT
    vecs.push_back(mk(32'h0040_0100,0,1,32'hDEAD_BEEF,0, 1,32'h0040_0008,0,32'h8C09_0010,32'h0040_0004,1)); // late ack, dropped
    vecs.push_back(mk(32'h0040_0100,0,0,32'h0,0,         0,32'h0040_0008,0,32'h8C09_0010,32'h0040_0004,1)); // ISSUE
    vecs.push_back(mk(32'h0040_0100,1,1,32'h1111_1111,0, 1,32'h0040_0100,0,32'h8C09_0010,32'h0040_0004,0)); // flush+ack
    vecs.push_back(mk(32'h0040_0200,0,0,32'h0,0,         0,32'h0040_0100,0,32'h8C09_0010,32'h0040_0004,1)); // ISSUE
    vecs.push_back(mk(32'h0040_0200,0,1,32'h2222_2222,0, 1,32'h0040_0200,0,32'h8C09_0010,32'h0040_0004,1)); // WAIT ack
    vecs.push_back(mk(32'h0040_0200,1,0,32'h0,1,         0,32'h0040_0200,1,32'h2222_2222,32'h0040_0200,0)); // OUT flush+ready
    vecs.push_back(mk(32'h0040_0300,1,0,32'h0,0,         0,32'h0040_0200,0,32'h2222_2222,32'h0040_0200,0)); // ISSUE flush
    vecs.push_back(mk(32'h0040_0400,0,0,32'h0,0,         0,32'h0040_0200,0,32'h2222_2222,32'h0040_0200,1)); // ISSUE resample
    vecs.push_back(mk(32'h0040_0400,0,1,32'h3333_3333,0, 1,32'h0040_0400,0,32'h2222_2222,32'h0040_0200,1)); // WAIT ack
    vecs.push_back(mk(32'h0040_0400,0,0,32'h0,1,         0,32'h0040_0400,1,32'h3333_3333,32'h0040_0400,0)); // OUT ready
    vecs.push_back(mk(32'h0040_0404,0,0,32'h0,0,         0,32'h0040_0400,0,32'h3333_3333,32'h0040_0400,1)); // ISSUE

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req_o},    32'd0);
    chk("rst_addr",  imem_addr_o,            32'd0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o,                NOP);
    chk("rst_ipc",   instr_pc_o,             32'd0);
    chk("rst_hold",  {31'd0, pc_hold_o},     32'd1);
    chk("rst_err",   {31'd0, fetch_err_o},   32'd0);
    reset_n = 1'b1;

    // Table-driven main sequence, one entry per clock cycle
    for (int i = 0; i < vecs.size(); i++) begin
      pc_i          = vecs[i].pc;
      flush_i       = vecs[i].flush;
      imem_ack_i    = vecs[i].ack;
      imem_rdata_i  = vecs[i].rdata;
      instr_ready_i = vecs[i].ready;
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req_o},    {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr_o,            vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid_o}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_instr", i), instr_o,                vecs[i].e_instr);
      chk($sformatf("v%0d_ipc", i),   instr_pc_o,             vecs[i].e_ipc);
      chk($sformatf("v%0d_hold", i),  {31'd0, pc_hold_o},     {31'd0, vecs[i].e_hold});
      chk($sformatf("v%0d_err", i),   {31'd0, fetch_err_o},   32'd0);
      next_cycle();
    end

    // Asynchronous reset in the middle of a WAIT
    flush_i = 1'b0; imem_ack_i = 1'b0; instr_ready_i = 1'b0;
    #1;
    chk("mid_wait_req",  {31'd0, imem_req_o}, 32'd1);
    chk("mid_wait_addr", imem_addr_o,         32'h0040_0404);
    reset_n = 1'b0;
    #1;
    chk("arst_req",   {31'd0, imem_req_o},    32'd0);
    chk("arst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("arst_instr", instr_o,                NOP);
    chk("arst_hold",  {31'd0, pc_hold_o},     32'd1);
    chk("arst_addr",  imem_addr_o,            32'd0);
    next_cycle();
    reset_n = 1'b1;

    // Flush during IDLE is visible on pc_hold; the FSM still moves to ISSUE
    pc_i = 32'h0040_0404; flush_i = 1'b1;
    #1;
    chk("idle_flush_hold", {31'd0, pc_hold_o},  32'd0);
    chk("idle_flush_req",  {31'd0, imem_req_o}, 32'd0);
    next_cycle();
    pc_i = 32'h0050_0000; flush_i = 1'b0;
    #1;
    chk("post_idle_hold", {31'd0, pc_hold_o},  32'd1);
    chk("post_idle_req",  {31'd0, imem_req_o}, 32'd0);
    next_cycle();

    // Memory never acknowledges
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("nak%0d_req", k),   {31'd0, imem_req_o},    32'd1);
      chk($sformatf("nak%0d_valid", k), {31'd0, instr_valid_o}, 32'd0);
      chk($sformatf("nak%0d_addr", k),  imem_addr_o,            32'h0050_0000);
      next_cycle();
    end
    #1;
`ifdef FETCH_TIMEOUT_EN
    chk("to_req",   {31'd0, imem_req_o},    32'd0);
    chk("to_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("to_instr", instr_o,                NOP);
    chk("to_ipc",   instr_pc_o,             32'h0050_0000);
    chk("to_err",   {31'd0, fetch_err_o},   32'd1);
    chk("to_hold",  {31'd0, pc_hold_o},     32'd1);
    instr_ready_i = 1'b1;
    #1;
    chk("to_deliver_hold", {31'd0, pc_hold_o}, 32'd0);
    next_cycle();
    instr_ready_i = 1'b0;
    pc_i = 32'h0050_0004;
    #1;
    chk("to_err_sticky", {31'd0, fetch_err_o},   32'd1);
    chk("to_issue_val",  {31'd0, instr_valid_o}, 32'd0);
`else
    chk("nto_req",   {31'd0, imem_req_o},    32'd1);
    chk("nto_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("nto_err",   {31'd0, fetch_err_o},   32'd0);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h4444_4444;
    next_cycle();
    imem_ack_i = 1'b0;
    #1;
    chk("nto_late_valid", {31'd0, instr_valid_o}, 32'd1);
    chk("nto_late_instr", instr_o,                32'h4444_4444);
    chk("nto_late_ipc",   instr_pc_o,             32'h0050_0000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
